jacaranda_wb_loader: RTL and testbench

Wishbone slave that lets the management SoC firmware (booted from the SPI flash image) load a program into the jacaranda-8 instruction memory and release the core from reset. It sits directly upstream of the jacaranda-8 core inside the user project area. It converts 32-bit Wishbone register writes into single-byte instruction-memory writes with auto-incrementing address, plus a byte count and checksum for firmware self-check.

---
 rtl/jacaranda_wb_loader.sv | 134 +++++++++++++
 tb/tb_jacaranda_wb_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jacaranda_wb_loader.sv
// rtl/jacaranda_wb_loader.sv - Wishbone loader that streams bytes into jacaranda-8 instruction memory
module jacaranda_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IMEM_AW   = 8
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [7:0]         imem_wdata,
    output logic               cpu_rst_n
);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    localparam logic [IMEM_AW:0]   CNT_MAX  = {1'b1, {IMEM_AW{1'b0}}};
    localparam logic [IMEM_AW:0]   CNT_ONE  = {{IMEM_AW{1'b0}}, 1'b1};
    localparam logic [IMEM_AW-1:0] ADDR_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    state_t             state;
    logic               run;
    logic [IMEM_AW-1:0] addr;
    logic [IMEM_AW:0]   count;
    logic [7:0]         sum;
    logic               err;

    logic               hit;
    logic [1:0]         reg_sel;
    logic [31:0]        rd_data;
    logic               unused_bits;

    assign hit     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = wbs_adr_i[3:2];

    // Only byte lane 0 and the word-aligned address bits carry meaning.
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL:   rd_data[0] = run;
            REG_ADDR:   rd_data[IMEM_AW-1:0] = addr;
            REG_STATUS: begin
                rd_data[IMEM_AW:0] = count;
                rd_data[23:16]     = sum;
                rd_data[31]        = err;
            end
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= S_IDLE;
            run        <= 1'b0;
            addr       <= '0;
            count      <= '0;
            sum        <= '0;
            err        <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            imem_we   <= 1'b0;
            cpu_rst_n <= run;
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        state     <= S_ACK;
                        wbs_ack_o <= 1'b1;
                        if (!wbs_we_i) begin
                            wbs_dat_o <= rd_data;
                        end else begin
                            case (reg_sel)
                                REG_CTRL: begin
                                    run <= wbs_dat_i[0];
                                    if (wbs_dat_i[1]) begin
                                        addr  <= '0;
                                        count <= '0;
                                        sum   <= '0;
                                        err   <= 1'b0;
                                    end
                                end
                                REG_ADDR: addr <= wbs_dat_i[IMEM_AW-1:0];
                                REG_DATA: begin
                                    if (wbs_sel_i[0]) begin
                                        // Loading into a running core would corrupt it; flag instead.
                                        if (run) begin
                                            err <= 1'b1;
                                        end else begin
                                            imem_we    <= 1'b1;
                                            imem_addr  <= addr;
                                            imem_wdata <= wbs_dat_i[7:0];
                                            addr       <= addr + ADDR_ONE;
                                            sum        <= sum + wbs_dat_i[7:0];
                                            if (count != CNT_MAX) begin
                                                count <= count + CNT_ONE;
                                            end
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jacaranda_wb_loader.sv
// tb/tb_jacaranda_wb_loader.sv - self-checking bench for jacaranda_wb_loader
module tb_jacaranda_wb_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we_i = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] adr_i = '0, dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_wdata;
    logic        cpu_rst_n;

    int errors = 0;
    int checks = 0;
    logic [15:0] mon_q[$];

    always #5 clock = ~clock;

    jacaranda_wb_loader #(.BASE_ADDR(BASE), .IMEM_AW(8)) dut (
        .clock(clock), .resetb(resetb),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
        .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n)
    );

    always @(negedge clock) if (imem_we) mon_q.push_back({imem_addr, imem_wdata});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_imem(input string name, input logic exp_wr, input logic [15:0] exp_item);
        chk({name, "_nwr"}, 32'(mon_q.size()), exp_wr ? 32'd1 : 32'd0);
        if (exp_wr && mon_q.size() > 0) chk(name, 32'(mon_q[0]), 32'(exp_item));
        mon_q.delete();
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic acked, output logic [31:0] rdata,
                             output logic rst_at_ack);
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        acked = 1'b0; rdata = '0; rst_at_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (wbs_ack_o) begin
                acked = 1'b1; rdata = wbs_dat_o; rst_at_ack = cpu_rst_n;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        @(negedge clock);
        if (acked) chk("ack_one_cycle", 32'(wbs_ack_o), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_wr;
        logic [15:0] exp_imem;
    } vec_t;

    vec_t tbl[9];

    // reference model state
    logic        m_run;
    int          m_addr, m_count, m_sum;
    logic        m_err;

    function automatic logic [31:0] model_read(input int r);
        case (r)
            0: return {31'b0, m_run};
            1: return 32'(m_addr);
            3: return {m_err, 7'b0, 8'(m_sum), 7'b0, 9'(m_count)};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic        ack, rst_ack;
        logic [31:0] rd;
        int          n;

        // reset
        #1;
        chk("rst_ack", 32'(wbs_ack_o), 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", 32'(imem_wdata), 0);
        chk("rst_cpu", 32'(cpu_rst_n), 0);
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clock);
            if (wbs_ack_o || imem_we) n++;
        end
        chk("idle_activity", 32'(n), 0);
        chk("idle_cpu", 32'(cpu_rst_n), 0);

        // load sequence
        tbl[0] = '{1'b1, 4'h4, 32'h10, 4'hF, 1'b0, 32'h0,        1'b0, 16'h0};
        tbl[1] = '{1'b1, 4'h8, 32'hA5, 4'h1, 1'b0, 32'h0,        1'b1, 16'h10A5};
        tbl[2] = '{1'b1, 4'h8, 32'h3C, 4'hF, 1'b0, 32'h0,        1'b1, 16'h113C};
        tbl[3] = '{1'b1, 4'h8, 32'hFF, 4'h1, 1'b0, 32'h0,        1'b1, 16'h12FF};
        tbl[4] = '{1'b0, 4'hC, 32'h0,  4'hF, 1'b1, 32'h00E0_0003, 1'b0, 16'h0};
        tbl[5] = '{1'b0, 4'h4, 32'h0,  4'hF, 1'b1, 32'h13,       1'b0, 16'h0};
        tbl[6] = '{1'b0, 4'h0, 32'h0,  4'hF, 1'b1, 32'h0,        1'b0, 16'h0};
        tbl[7] = '{1'b0, 4'h8, 32'h0,  4'hF, 1'b1, 32'h0,        1'b0, 16'h0};
        tbl[8] = '{1'b1, 4'h8, 32'h77, 4'hE, 1'b0, 32'h0,        1'b0, 16'h0};
        mon_q.delete();
        for (int i = 0; i < 9; i++) begin
            wb_access(tbl[i].we, BASE + 32'(tbl[i].off), tbl[i].dat, tbl[i].sel, ack, rd, rst_ack);
            chk($sformatf("tbl%0d_ack", i), 32'(ack), 1);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            chk_imem($sformatf("tbl%0d_imem", i), tbl[i].exp_wr, tbl[i].exp_imem);
        end

        // back-to-back: stb held, one ack every two cycles
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = BASE + 32'h4;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (wbs_ack_o) n++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("b2b_acks", 32'(n), 3);
        @(negedge clock);

        // run lock
        wb_access(1'b1, BASE, 32'h1, 4'hF, ack, rd, rst_ack);
        chk("run_rst_at_ack", 32'(rst_ack), 0);
        chk("run_rst_after", 32'(cpu_rst_n), 1);
        wb_access(1'b1, BASE + 32'h8, 32'h55, 4'hF, ack, rd, rst_ack);
        chk("lock_ack", 32'(ack), 1);
        chk_imem("lock_imem", 1'b0, 16'h0);
        wb_access(1'b0, BASE + 32'hC, 0, 4'hF, ack, rd, rst_ack);
        chk("lock_status", rd, 32'h80E0_0003);
        wb_access(1'b1, BASE, 32'h2, 4'hF, ack, rd, rst_ack);
        wb_access(1'b0, BASE + 32'hC, 0, 4'hF, ack, rd, rst_ack);
        chk("clr_status", rd, 32'h0);
        wb_access(1'b0, BASE + 32'h4, 0, 4'hF, ack, rd, rst_ack);
        chk("clr_addr", rd, 32'h0);
        chk("clr_cpu", 32'(cpu_rst_n), 0);

        // decode miss
        wb_access(1'b1, BASE + 32'h10, 32'h1, 4'hF, ack, rd, rst_ack);
        chk("miss_ack", 32'(ack), 0);
        wb_access(1'b0, BASE, 0, 4'hF, ack, rd, rst_ack);
        chk("miss_run", rd, 32'h0);

        // wrap and saturate
        wb_access(1'b1, BASE + 32'h4, 32'hFF, 4'hF, ack, rd, rst_ack);
        mon_q.delete();
        n = 0;
        for (int i = 0; i < 257; i++) begin
            wb_access(1'b1, BASE + 32'h8, 32'h01, 4'h1, ack, rd, rst_ack);
            if (i == 0) chk_imem("wrap_first", 1'b1, 16'hFF01);
            else if (i == 1) chk_imem("wrap_second", 1'b1, 16'h0001);
            else begin
                if (mon_q.size() == 1) n++;
                mon_q.delete();
            end
        end
        chk("wrap_rest_writes", 32'(n), 255);
        wb_access(1'b0, BASE + 32'hC, 0, 4'hF, ack, rd, rst_ack);
        chk("sat_status", rd, 32'h0001_0100);

        // async reset during ACK
        wb_access(1'b1, BASE + 32'h4, 32'h40, 4'hF, ack, rd, rst_ack);
        wb_access(1'b1, BASE, 32'h1, 4'hF, ack, rd, rst_ack);
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = BASE; dat_i = 32'h0; sel_i = 4'hF;
        @(posedge clock); #1;
        chk("ar_ack_pre", 32'(wbs_ack_o), 1);
        #1 resetb = 1'b0;
        #1;
        chk("ar_ack", 32'(wbs_ack_o), 0);
        chk("ar_we", 32'(imem_we), 0);
        chk("ar_cpu", 32'(cpu_rst_n), 0);
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        mon_q.delete();
        wb_access(1'b0, BASE + 32'h4, 0, 4'hF, ack, rd, rst_ack);
        chk("ar_addr", rd, 32'h0);
        wb_access(1'b0, BASE + 32'hC, 0, 4'hF, ack, rd, rst_ack);
        chk("ar_status", rd, 32'h0);

        // randomized against reference model
        m_run = 1'b0; m_addr = 0; m_count = 0; m_sum = 0; m_err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            int          r, pick;
            logic        w, exp_wr;
            logic [31:0] d;
            logic [3:0]  s;
            logic [15:0] exp_item;
            pick = int'($urandom_range(0, 9));
            r = (pick == 0) ? 0 : (pick == 1) ? 1 : (pick < 7) ? 2 : 3;
            w = (r == 2) ? ($urandom_range(0, 5) != 0) : 1'($urandom_range(0, 1));
            d = $urandom;
            if (r == 0 && $urandom_range(0, 2) != 0) d[0] = 1'b0;
            s = 4'($urandom);
            exp_wr = 1'b0; exp_item = '0;
            wb_access(w, BASE + 32'(r * 4), d, s, ack, rd, rst_ack);
            chk("rnd_ack", 32'(ack), 1);
            if (!w) begin
                chk($sformatf("rnd%0d_rd_r%0d", i, r), rd, model_read(r));
            end else begin
                case (r)
                    0: begin
                        if (d[1]) begin m_addr = 0; m_count = 0; m_sum = 0; m_err = 1'b0; end
                        m_run = d[0];
                    end
                    1: m_addr = int'(d[7:0]);
                    2: if (s[0]) begin
                        if (m_run) m_err = 1'b1;
                        else begin
                            exp_wr = 1'b1;
                            exp_item = {8'(m_addr), d[7:0]};
                            m_addr = (m_addr + 1) % 256;
                            m_count = (m_count < 256) ? m_count + 1 : 256;
                            m_sum = (m_sum + int'(d[7:0])) % 256;
                        end
                    end
                    default: ;
                endcase
            end
            chk_imem($sformatf("rnd%0d_imem", i), exp_wr, exp_item);
            chk($sformatf("rnd%0d_cpu", i), 32'(cpu_rst_n), 32'(m_run));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
